// File: rtl/ysyx_25040111_pkg.sv
// Shared encodings for the LSU: request size codes, FSM states, fault causes
// and the AXI constants the LSU drives.
package ysyx_25040111_pkg;

    // in_rmask / in_wmask size codes; 2'b10 and 2'b11 both mean word
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // errtp fault causes
    localparam logic [3:0] ERRTP_NONE           = 4'd0;
    localparam logic [3:0] ERRTP_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] ERRTP_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] ERRTP_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] ERRTP_STORE_FAULT    = 4'd7;

    // AXI constants
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [3:0] AXI_ID_LSU      = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } lsu_state_e;

    // AXI beat size: bursts (cache fills) and words are always full width
    function automatic logic [2:0] axi_size(input logic [1:0] size, input logic burst);
        if (burst || size[1])
            return 3'd2;
        else if (size == SIZE_HALF)
            return 3'd1;
        else
            return 3'd0;
    endfunction

    // Half at an odd byte, or word off a word boundary; bursts are never checked
    function automatic logic misaligned(input logic [1:0] size, input logic burst,
                                        input logic [1:0] addr_lo);
        if (burst)
            return 1'b0;
        else if (size[1])
            return addr_lo != 2'b00;
        else if (size == SIZE_HALF)
            return addr_lo[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_if.sv
// AXI4 bus between the LSU (master) and the SoC crossbar (slave).
interface ysyx_25040111_lsu_if;

    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;

    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [3:0]  m_rid;

    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;

    logic        m_wvalid;
    logic        m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;

    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic [3:0]  m_bid;

    modport master (
        output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        output m_rready,
        output m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp, m_bid,
        output m_bready
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
        output m_arready,
        output m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        input  m_rready,
        input  m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp, m_bid,
        input  m_bready
    );

endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane handling: read-side shift/mask/extend and write-side shift/strobe.
// Purely combinational.
module ysyx_25040111_lsu_align
    import ysyx_25040111_pkg::*;
(
    input  logic [31:0] rdata_raw,
    input  logic [1:0]  raddr_lo,
    input  logic [1:0]  rsize,
    input  logic        rsign,
    input  logic        rburst,
    output logic [31:0] rdata,

    input  logic [31:0] wdata_raw,
    input  logic [1:0]  waddr_lo,
    input  logic [1:0]  wsize,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [31:0] rshift;
    logic [4:0]  rsh_amt;
    logic [4:0]  wsh_amt;

    assign rsh_amt = {raddr_lo, 3'b000};
    assign wsh_amt = {waddr_lo, 3'b000};

    // Sub-word loads: bring the addressed lane down, then sign or zero extend.
    // Words and burst beats pass through untouched.
    always_comb begin
        rshift = rdata_raw >> rsh_amt;
        rdata  = rdata_raw;
        if (!rburst && !rsize[1]) begin
            if (rsize == SIZE_HALF)
                rdata = {{16{rsign & rshift[15]}}, rshift[15:0]};
            else
                rdata = {{24{rsign & rshift[7]}}, rshift[7:0]};
        end
    end

    // Stores: move the data up to its lane; lanes shifted past byte 3 are dropped.
    always_comb begin
        wdata = wdata_raw << wsh_amt;
        if (wsize[1])
            wstrb = 4'b1111;
        else if (wsize == SIZE_HALF)
            wstrb = 4'b0011 << waddr_lo;
        else
            wstrb = 4'b0001 << waddr_lo;
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store unit: converts single-outstanding arbiter read/write requests into
// AXI4 master transactions, and passes instruction-cache INCR burst fills.
// Optional build macro YSYX_25040111_MISALIGN_CHK_EN: misaligned non-burst
// accesses are trapped locally (errtp 4/6) instead of being issued to AXI.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; read wins when both are pending
// ST_RD_ADDR | m_arvalid held until m_arready
// ST_RD_DATA | m_rready high; each beat forwarded to in_rready until rlast
// ST_WR_REQ  | AW and W raised together, each dropped after its handshake
// ST_WR_RESP | m_bready high; B response completes the store
module ysyx_25040111_lsu
    import ysyx_25040111_pkg::*;
(
    input  logic        clock,
    input  logic        reset,

    input  logic        in_rvalid,
    output logic        in_rready,
    output logic [31:0] in_rdata,
    input  logic [31:0] in_raddr,
    input  logic [7:0]  in_rlen,
    input  logic        in_burst,
    input  logic        in_rsign,
    input  logic [1:0]  in_rmask,

    input  logic        in_wvalid,
    output logic        in_wready,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_waddr,
    input  logic [1:0]  in_wmask,

    output logic        err,
    output logic [3:0]  errtp,

    ysyx_25040111_lsu_if.master axi
);

    lsu_state_e  state_q, state_d;

    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, wlast_q;
    logic [31:0] araddr_q, awaddr_q, wdata_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q, awsize_q;
    logic [1:0]  arburst_q, awburst_q;
    logic [3:0]  wstrb_q;

    logic [1:0]  rsize_q;
    logic        rsign_q, rburst_q;
    logic [7:0]  beats_left_q;

    logic        rd_go, wr_go, rd_mis, wr_mis, rd_issue, wr_issue;
    logic        mis_rd_q, mis_wr_q, pulse_block;
    logic        ar_hs, aw_hs, w_hs, r_beat, b_beat, aw_done, w_done;
    logic        rd_fault;
    logic [31:0] rdata_aligned, wdata_shifted;
    logic [3:0]  wstrb_gen;
    logic        unused_bits;

    assign ar_hs   = axi.m_arvalid & axi.m_arready;
    assign aw_hs   = axi.m_awvalid & axi.m_awready;
    assign w_hs    = axi.m_wvalid & axi.m_wready;
    assign r_beat  = axi.m_rvalid & axi.m_rready;
    assign b_beat  = axi.m_bvalid & axi.m_bready;
    assign aw_done = !axi.m_awvalid | axi.m_awready;
    assign w_done  = !axi.m_wvalid | axi.m_wready;

    // A trapped misaligned access answers next cycle while its request is
    // still held, so acceptance is blocked for that one cycle.
    assign pulse_block = mis_rd_q | mis_wr_q;
    assign rd_go       = (state_q == ST_IDLE) & in_rvalid & !pulse_block;
    assign wr_go       = (state_q == ST_IDLE) & !in_rvalid & in_wvalid & !pulse_block;
    assign rd_issue    = rd_go & !rd_mis;
    assign wr_issue    = wr_go & !wr_mis;

`ifdef YSYX_25040111_MISALIGN_CHK_EN
    assign rd_mis = misaligned(in_rmask, in_burst, in_raddr[1:0]);
    assign wr_mis = misaligned(in_wmask, 1'b0, in_waddr[1:0]);

    // One-cycle local fault response for a trapped misaligned access
    always_ff @(posedge clock) begin
        if (reset) begin
            mis_rd_q <= 1'b0;
            mis_wr_q <= 1'b0;
        end else begin
            mis_rd_q <= rd_go & rd_mis;
            mis_wr_q <= wr_go & wr_mis;
        end
    end
`else
    assign rd_mis   = 1'b0;
    assign wr_mis   = 1'b0;
    assign mis_rd_q = 1'b0;
    assign mis_wr_q = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_issue)
                    state_d = ST_RD_ADDR;
                else if (wr_issue)
                    state_d = ST_WR_REQ;
            end
            ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: if (r_beat && axi.m_rlast) state_d = ST_IDLE;
            ST_WR_REQ:  if (aw_done && w_done) state_d = ST_WR_RESP;
            ST_WR_RESP: if (b_beat) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered AXI outputs, request latches and the read beat down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awsize_q     <= '0;
            awburst_q    <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            rsize_q      <= '0;
            rsign_q      <= 1'b0;
            rburst_q     <= 1'b0;
            beats_left_q <= '0;
        end else begin
            if (rd_issue) begin
                arvalid_q    <= 1'b1;
                araddr_q     <= in_raddr;
                arlen_q      <= in_burst ? in_rlen : 8'd0;
                arsize_q     <= axi_size(in_rmask, in_burst);
                arburst_q    <= AXI_BURST_INCR;
                rsize_q      <= in_rmask;
                rsign_q      <= in_rsign;
                rburst_q     <= in_burst;
                beats_left_q <= in_burst ? in_rlen : 8'd0;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end

            if (r_beat) begin
                if (axi.m_rlast)
                    rready_q <= 1'b0;
                if (beats_left_q != 8'd0)
                    beats_left_q <= beats_left_q - 8'd1;
            end

            if (wr_issue) begin
                awvalid_q <= 1'b1;
                awaddr_q  <= in_waddr;
                awsize_q  <= axi_size(in_wmask, 1'b0);
                awburst_q <= AXI_BURST_INCR;
                wvalid_q  <= 1'b1;
                wdata_q   <= wdata_shifted;
                wstrb_q   <= wstrb_gen;
                wlast_q   <= 1'b1;
            end else begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs)  wvalid_q  <= 1'b0;
            end

            if (state_q == ST_WR_REQ && aw_done && w_done)
                bready_q <= 1'b1;
            else if (b_beat)
                bready_q <= 1'b0;
        end
    end

    ysyx_25040111_lsu_align u_align (
        .rdata_raw (axi.m_rdata),
        .raddr_lo  (araddr_q[1:0]),
        .rsize     (rsize_q),
        .rsign     (rsign_q),
        .rburst    (rburst_q),
        .rdata     (rdata_aligned),
        .wdata_raw (in_wdata),
        .waddr_lo  (in_waddr[1:0]),
        .wsize     (in_wmask),
        .wdata     (wdata_shifted),
        .wstrb     (wstrb_gen)
    );

    // Early/late rlast is judged against the down-counter reaching zero
    assign rd_fault = axi.m_rresp[1] | (axi.m_rlast != (beats_left_q == 8'd0));

    assign in_rready = r_beat | mis_rd_q;
    assign in_wready = b_beat | mis_wr_q;
    assign in_rdata  = r_beat ? rdata_aligned : 32'd0;

    // Fault reporting, aligned with the in_rready/in_wready pulse
    always_comb begin
        err   = 1'b0;
        errtp = ERRTP_NONE;
        if (mis_rd_q) begin
            err   = 1'b1;
            errtp = ERRTP_LOAD_MISALIGN;
        end else if (mis_wr_q) begin
            err   = 1'b1;
            errtp = ERRTP_STORE_MISALIGN;
        end else if (r_beat && rd_fault) begin
            err   = 1'b1;
            errtp = ERRTP_LOAD_FAULT;
        end else if (b_beat && axi.m_bresp[1]) begin
            err   = 1'b1;
            errtp = ERRTP_STORE_FAULT;
        end
    end

    assign axi.m_arvalid = arvalid_q;
    assign axi.m_araddr  = araddr_q;
    assign axi.m_arid    = AXI_ID_LSU;
    assign axi.m_arlen   = arlen_q;
    assign axi.m_arsize  = arsize_q;
    assign axi.m_arburst = arburst_q;
    assign axi.m_rready  = rready_q;
    assign axi.m_awvalid = awvalid_q;
    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_awid    = AXI_ID_LSU;
    assign axi.m_awlen   = 8'd0;
    assign axi.m_awsize  = awsize_q;
    assign axi.m_awburst = awburst_q;
    assign axi.m_wvalid  = wvalid_q;
    assign axi.m_wdata   = wdata_q;
    assign axi.m_wstrb   = wstrb_q;
    assign axi.m_wlast   = wlast_q;
    assign axi.m_bready  = bready_q;

    // Only one ID is ever issued and only the error bit of resp matters
    assign unused_bits = ^{axi.m_rid, axi.m_bid, axi.m_rresp[0], axi.m_bresp[0]};

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed bench for ysyx_25040111_lsu with a response scoreboard.
module tb_ysyx_25040111_lsu;
    import ysyx_25040111_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_rvalid, in_rready, in_burst, in_rsign;
    logic [31:0] in_rdata, in_raddr;
    logic [7:0]  in_rlen;
    logic [1:0]  in_rmask;
    logic        in_wvalid, in_wready;
    logic [31:0] in_wdata, in_waddr;
    logic [1:0]  in_wmask;
    logic        err;
    logic [3:0]  errtp;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  errtp;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    ysyx_25040111_lsu_if axi();

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata),
        .in_raddr(in_raddr), .in_rlen(in_rlen), .in_burst(in_burst),
        .in_rsign(in_rsign), .in_rmask(in_rmask),
        .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata),
        .in_waddr(in_waddr), .in_wmask(in_wmask),
        .err(err), .errtp(errtp),
        .axi(axi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic is_rd, input logic [31:0] d, input logic e, input logic [3:0] tp);
        exp_t x;
        x.is_rd = is_rd; x.rdata = d; x.err = e; x.errtp = tp;
        exp_q.push_back(x);
    endtask

    // Monitor: every response pulse is checked against the oldest expectation
    always @(negedge clock) begin
        if (!reset && (in_rready || in_wready)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_kind", {31'd0, in_rready}, {31'd0, e.is_rd});
                if (e.is_rd) chk("resp_rdata", in_rdata, e.rdata);
                chk("resp_err", {31'd0, err}, {31'd0, e.err});
                chk("resp_errtp", {28'd0, errtp}, {28'd0, e.errtp});
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'd0, axi.m_arvalid}, 0);
        chk({tag, "_rready"},  {31'd0, axi.m_rready}, 0);
        chk({tag, "_awvalid"}, {31'd0, axi.m_awvalid}, 0);
        chk({tag, "_wvalid"},  {31'd0, axi.m_wvalid}, 0);
        chk({tag, "_bready"},  {31'd0, axi.m_bready}, 0);
        chk({tag, "_in_rready"}, {31'd0, in_rready}, 0);
        chk({tag, "_in_wready"}, {31'd0, in_wready}, 0);
        chk({tag, "_err"},     {31'd0, err}, 0);
        chk({tag, "_errtp"},   {28'd0, errtp}, 0);
        chk({tag, "_araddr"},  axi.m_araddr, 0);
        chk({tag, "_wdata"},   axi.m_wdata, 0);
    endtask

    // Single (non-burst) load; slave answers AR immediately and R one cycle later
    task automatic single_load(input logic [31:0] addr, input logic [1:0] mask, input logic sign,
                               input logic [31:0] rd, input logic [1:0] resp,
                               input logic [31:0] exp_d, input logic exp_e, input logic [3:0] exp_tp,
                               input logic [2:0] exp_size);
        in_rvalid = 1; in_raddr = addr; in_rmask = mask; in_rsign = sign; in_burst = 0; in_rlen = 0;
        axi.m_arready = 1;
        push(1'b1, exp_d, exp_e, exp_tp);
        tick();
        chk("ld_arvalid", {31'd0, axi.m_arvalid}, 1);
        chk("ld_araddr", axi.m_araddr, addr);
        chk("ld_arsize", {29'd0, axi.m_arsize}, {29'd0, exp_size});
        chk("ld_arlen", {24'd0, axi.m_arlen}, 0);
        tick();
        axi.m_rvalid = 1; axi.m_rdata = rd; axi.m_rlast = 1; axi.m_rresp = resp;
        #1;
        chk("ld_latency_in_rready", {31'd0, in_rready}, 1);
        tick();
        in_rvalid = 0; axi.m_rvalid = 0; axi.m_rlast = 0; axi.m_rresp = 0;
        chk("ld_rready_dropped", {31'd0, axi.m_rready}, 0);
    endtask

    // Single store with immediate AW/W readiness and B two cycles after acceptance
    task automatic single_store(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] d,
                                input logic [1:0] bresp, input logic [31:0] exp_wd,
                                input logic [3:0] exp_strb, input logic exp_e, input logic [3:0] exp_tp);
        in_wvalid = 1; in_waddr = addr; in_wmask = mask; in_wdata = d;
        axi.m_awready = 1; axi.m_wready = 1;
        push(1'b0, 32'd0, exp_e, exp_tp);
        tick();
        chk("st_awvalid", {31'd0, axi.m_awvalid}, 1);
        chk("st_wdata", axi.m_wdata, exp_wd);
        chk("st_wstrb", {28'd0, axi.m_wstrb}, {28'd0, exp_strb});
        tick();
        axi.m_bvalid = 1; axi.m_bresp = bresp;
        tick();
        axi.m_bvalid = 0; axi.m_bresp = 0; in_wvalid = 0;
    endtask

    initial begin
        logic [31:0] bdata [4];
        int          gaps  [4];
        bdata[0] = 32'h1111_2222; bdata[1] = 32'h3333_4444;
        bdata[2] = 32'h5555_6666; bdata[3] = 32'h7777_8888;
        gaps[0] = 1; gaps[1] = 0; gaps[2] = 2; gaps[3] = 1;

        reset = 1;
        in_rvalid = 0; in_raddr = 0; in_rlen = 0; in_burst = 0; in_rsign = 0; in_rmask = 0;
        in_wvalid = 0; in_wdata = 0; in_waddr = 0; in_wmask = 0;
        axi.m_arready = 0; axi.m_rvalid = 0; axi.m_rdata = 0; axi.m_rresp = 0;
        axi.m_rlast = 0; axi.m_rid = 0; axi.m_awready = 0; axi.m_wready = 0;
        axi.m_bvalid = 0; axi.m_bresp = 0; axi.m_bid = 0;
        tick(); tick();
        check_idle_outputs("reset");
        reset = 0;
        tick();

        // Signed byte load from the top lane
        single_load(32'h8000_0003, SIZE_BYTE, 1'b1, 32'h80FF_FFFF, 2'b00,
                    32'hFFFF_FF80, 1'b0, ERRTP_NONE, 3'd0);
        tick();
        // Unsigned half load, low lane
        single_load(32'h8000_0000, SIZE_HALF, 1'b0, 32'h1234_F00D, 2'b00,
                    32'h0000_F00D, 1'b0, ERRTP_NONE, 3'd1);
        tick();
        // Signed half load, upper lane, with SLVERR
        single_load(32'h8000_0002, SIZE_HALF, 1'b1, 32'h8001_7FFF, 2'b10,
                    32'hFFFF_8001, 1'b1, ERRTP_LOAD_FAULT, 3'd1);
        tick();

        // Cache burst fill, AR stalled one cycle, gaps between R beats
        in_rvalid = 1; in_raddr = 32'h3000_0000; in_rmask = SIZE_WORD; in_rsign = 0;
        in_burst = 1; in_rlen = 8'd3; axi.m_arready = 0;
        for (int i = 0; i < 4; i++) push(1'b1, bdata[i], 1'b0, ERRTP_NONE);
        tick();
        chk("burst_arlen", {24'd0, axi.m_arlen}, 3);
        chk("burst_arsize", {29'd0, axi.m_arsize}, 2);
        chk("burst_arburst", {30'd0, axi.m_arburst}, {30'd0, AXI_BURST_INCR});
        tick();
        chk("burst_arvalid_held", {31'd0, axi.m_arvalid}, 1);
        axi.m_arready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            axi.m_rvalid = 0;
            repeat (gaps[i]) tick();
            axi.m_rvalid = 1; axi.m_rdata = bdata[i]; axi.m_rlast = (i == 3);
            tick();
        end
        axi.m_rvalid = 0; axi.m_rlast = 0; in_rvalid = 0; in_burst = 0; in_rlen = 0;
        chk("burst_done_rready", {31'd0, axi.m_rready}, 0);
        tick();

        // Half store at byte 2; W accepted first, AW two cycles later
        in_wvalid = 1; in_waddr = 32'h8000_0002; in_wdata = 32'h0000_1234; in_wmask = SIZE_HALF;
        axi.m_awready = 0; axi.m_wready = 0;
        push(1'b0, 32'd0, 1'b0, ERRTP_NONE);
        tick();
        chk("sh_wdata", axi.m_wdata, 32'h1234_0000);
        chk("sh_wstrb", {28'd0, axi.m_wstrb}, 32'h0000_000C);
        chk("sh_wlast", {31'd0, axi.m_wlast}, 1);
        chk("sh_awlen", {24'd0, axi.m_awlen}, 0);
        axi.m_wready = 1;
        tick();
        axi.m_wready = 0;
        chk("sh_wvalid_dropped", {31'd0, axi.m_wvalid}, 0);
        chk("sh_awvalid_held", {31'd0, axi.m_awvalid}, 1);
        tick();
        chk("sh_no_early_wready", {31'd0, in_wready}, 0);
        axi.m_awready = 1;
        tick();
        axi.m_awready = 0;
        chk("sh_awvalid_dropped", {31'd0, axi.m_awvalid}, 0);
        axi.m_bvalid = 1; axi.m_bresp = 2'b00;
        #1;
        chk("sh_in_wready_on_b", {31'd0, in_wready}, 1);
        tick();
        axi.m_bvalid = 0; in_wvalid = 0;
        tick();

        // Simultaneous read and write: read first, write in the following IDLE cycle
        in_rvalid = 1; in_raddr = 32'h8000_0010; in_rmask = SIZE_WORD; in_rsign = 0;
        in_wvalid = 1; in_waddr = 32'h8000_0021; in_wdata = 32'h0000_00AB; in_wmask = SIZE_BYTE;
        axi.m_arready = 1; axi.m_awready = 1; axi.m_wready = 1;
        push(1'b1, 32'hCAFE_F00D, 1'b0, ERRTP_NONE);
        push(1'b0, 32'd0, 1'b0, ERRTP_NONE);
        tick();
        chk("both_ar_first", {31'd0, axi.m_arvalid}, 1);
        chk("both_aw_not_yet", {31'd0, axi.m_awvalid}, 0);
        tick();
        axi.m_rvalid = 1; axi.m_rdata = 32'hCAFE_F00D; axi.m_rlast = 1;
        tick();
        axi.m_rvalid = 0; axi.m_rlast = 0; in_rvalid = 0;
        chk("both_aw_idle_cycle", {31'd0, axi.m_awvalid}, 0);
        tick();
        chk("both_aw_started", {31'd0, axi.m_awvalid}, 1);
        chk("both_wdata", axi.m_wdata, 32'h0000_AB00);
        chk("both_wstrb", {28'd0, axi.m_wstrb}, 32'h0000_0002);
        tick();
        axi.m_bvalid = 1; axi.m_bresp = 0;
        tick();
        axi.m_bvalid = 0; in_wvalid = 0;
        tick();

        // Store fault
        single_store(32'h0000_0000, SIZE_WORD, 32'hDEAD_BEEF, 2'b10,
                     32'hDEAD_BEEF, 4'b1111, 1'b1, ERRTP_STORE_FAULT);
        tick();

        // Early rlast on beat 2 of a 4-beat burst
        in_rvalid = 1; in_raddr = 32'h3000_0040; in_rmask = SIZE_WORD; in_burst = 1; in_rlen = 8'd3;
        axi.m_arready = 1;
        push(1'b1, 32'hAAAA_0001, 1'b0, ERRTP_NONE);
        push(1'b1, 32'hAAAA_0002, 1'b1, ERRTP_LOAD_FAULT);
        tick(); tick();
        axi.m_rvalid = 1; axi.m_rdata = 32'hAAAA_0001; axi.m_rlast = 0;
        tick();
        axi.m_rdata = 32'hAAAA_0002; axi.m_rlast = 1;
        tick();
        axi.m_rvalid = 0; axi.m_rlast = 0; in_rvalid = 0; in_burst = 0; in_rlen = 0;
        chk("early_rlast_rready", {31'd0, axi.m_rready}, 0);
        tick();

`ifdef YSYX_25040111_MISALIGN_CHK_EN
        // Misaligned word load and half store are trapped locally
        in_rvalid = 1; in_raddr = 32'h8000_0001; in_rmask = SIZE_WORD; in_burst = 0;
        push(1'b1, 32'd0, 1'b1, ERRTP_LOAD_MISALIGN);
        tick();
        chk("mis_ld_no_arvalid", {31'd0, axi.m_arvalid}, 0);
        chk("mis_ld_in_rready", {31'd0, in_rready}, 1);
        tick();
        in_rvalid = 0;
        chk("mis_ld_single_pulse", {31'd0, axi.m_arvalid}, 0);
        tick();
        in_wvalid = 1; in_waddr = 32'h8000_0003; in_wmask = SIZE_HALF; in_wdata = 32'h5555;
        push(1'b0, 32'd0, 1'b1, ERRTP_STORE_MISALIGN);
        tick();
        chk("mis_st_no_awvalid", {31'd0, axi.m_awvalid}, 0);
        tick();
        in_wvalid = 0;
        tick();
`else
        // Misaligned word load is issued as-is and passes through unshifted
        single_load(32'h8000_0001, SIZE_WORD, 1'b0, 32'h0102_0304, 2'b00,
                    32'h0102_0304, 1'b0, ERRTP_NONE, 3'd2);
        tick();
`endif

        // Reset during RD_DATA abandons the read
        in_rvalid = 1; in_raddr = 32'h8000_0100; in_rmask = SIZE_WORD; in_burst = 0;
        axi.m_arready = 1;
        tick(); tick();
        chk("rst_mid_in_rd_data", {31'd0, axi.m_rready}, 1);
        reset = 1; in_rvalid = 0;
        tick();
        check_idle_outputs("rst_mid");
        reset = 0;
        tick();
        single_load(32'h8000_0101, SIZE_BYTE, 1'b0, 32'h0000_9900, 2'b00,
                    32'h0000_0099, 1'b0, ERRTP_NONE, 3'd0);
        tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
